io_tx_buffer: RTL and testbench

IO_TX_BUFFER -- requirements
Module: io_tx_buffer

---
 rtl/io_tx_buffer_if.sv | 23 ++
 rtl/io_tx_buffer.sv | 100 ++++++++++
 tb/tb_io_tx_buffer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_tx_buffer_if.sv
// CPU-bus and UART-transmit signal bundle for io_tx_buffer.
// Handshake: a byte moves on tx_data at a rising edge where tx_valid and tx_ready are both 1;
// while tx_valid=1 and tx_ready=0 the source holds tx_data stable.
interface io_tx_buffer_if;
  logic        rdy_in;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport slave (
    input  rdy_in, mem_dout, mem_a, mem_wr, tx_ready,
    output io_buffer_full, tx_data, tx_valid
  );

  modport master (
    output rdy_in, mem_dout, mem_a, mem_wr, tx_ready,
    input  io_buffer_full, tx_data, tx_valid
  );
endinterface

// File: rtl/io_tx_buffer.sv
// Memory-mapped CPU console: buffers bytes written to the IO data port and streams them to a UART,
// and on a stop write drains the buffer, sends a terminating NUL and halts until reset.
module io_tx_buffer #(
  parameter int DEPTH       = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  io_tx_buffer_if.slave       bus,
  output logic                prog_stop,
  output logic                overflow,
  output logic [1:0]          dbg_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_TH_C = CW'(DEPTH - FULL_MARGIN);

  typedef enum logic [1:0] {RUN, STOPPING, SEND_NUL, HALTED} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      mem_q [DEPTH];

  logic io_sel, stop_wr, data_wr;
  logic fifo_out, pop, push, drop, full_now;
  logic unused_addr_bits;

  // Only bits 17:16 select the IO block and bit 2 selects data vs stop.
  assign unused_addr_bits = ^{bus.mem_a[31:18], bus.mem_a[15:3], bus.mem_a[1:0]};

  assign io_sel  = bus.rdy_in & bus.mem_wr & (bus.mem_a[17:16] == 2'b11);
  assign stop_wr = io_sel & bus.mem_a[2];
  assign data_wr = io_sel & ~bus.mem_a[2] & (bus.mem_dout != 8'h00);

  assign fifo_out = (count_q != '0) && ((state_q == RUN) || (state_q == STOPPING));
  assign pop      = fifo_out & bus.tx_ready;
  assign full_now = (count_q == DEPTH_C);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push     = (state_q == RUN) & data_wr & (~full_now | pop);
  assign drop     = (state_q == RUN) & data_wr & full_now & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | drop;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Stop decisions look at the post-edge count so no idle cycle appears before the NUL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (stop_wr) state_d = (count_d == '0) ? SEND_NUL : STOPPING;
      STOPPING: if (count_d == '0) state_d = SEND_NUL;
      SEND_NUL: if (bus.tx_ready) state_d = HALTED;
      HALTED:   state_d = HALTED;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= bus.mem_dout;
  end

  assign bus.tx_valid       = fifo_out | (state_q == SEND_NUL);
  assign bus.tx_data        = (state_q == SEND_NUL) ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.io_buffer_full = (count_q >= FULL_TH_C) | (state_q != RUN);
  assign prog_stop          = (state_q == HALTED);
  assign overflow           = ovf_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_io_tx_buffer.sv
// Bench for io_tx_buffer: vector table, directed corner sequences, and randomized traffic
// compared against a queue-based model of the console behaviour.
module tb_io_tx_buffer;

  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

  logic       clk;
  logic       rst;
  logic       prog_stop;
  logic       overflow;
  logic [1:0] dbg_state;
  io_tx_buffer_if bus();

  io_tx_buffer #(.DEPTH(DEPTH), .FULL_MARGIN(MARGIN)) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .bus         (bus),
    .prog_stop   (prog_stop),
    .overflow    (overflow),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- driver tasks ----------------
  task automatic set_bus(input logic rdy, input logic wr, input logic [31:0] a,
                         input logic [7:0] d, input logic txr);
    bus.rdy_in   = rdy;
    bus.mem_wr   = wr;
    bus.mem_a    = a;
    bus.mem_dout = d;
    bus.tx_ready = txr;
  endtask

  task automatic idle(input logic txr);
    set_bus(1'b1, 1'b0, 32'h0, 8'h00, txr);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle(1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic txr);
    set_bus(1'b1, 1'b1, 32'h0003_0000, d, txr);
    tick();
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic v, input logic [7:0] d,
                           input logic f, input logic s, input logic o);
    check({name, ".tx_valid"}, 32'(bus.tx_valid), 32'(v));
    if (v) check({name, ".tx_data"}, 32'(bus.tx_data), 32'(d));
    check({name, ".full"}, 32'(bus.io_buffer_full), 32'(f));
    check({name, ".prog_stop"}, 32'(prog_stop), 32'(s));
    check({name, ".overflow"}, 32'(overflow), 32'(o));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rdy;
    logic        wr;
    logic [31:0] a;
    logic [7:0]  d;
    logic        txr;
    logic        v;
    logic [7:0]  dat;
    logic        full;
    logic        stop;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];
  bit m_stop, m_halt, m_ovf;

  task automatic model_reset;
    exp_q.delete();
    m_stop = 0;
    m_halt = 0;
    m_ovf  = 0;
  endtask

  // Applies the console rules to the inputs present at the coming edge.
  task automatic model_step;
    bit popd, io, is_stop;
    if (rst) begin
      model_reset();
    end else if (m_halt) begin
      // halted: nothing changes until reset
    end else if (m_stop) begin
      if (exp_q.size() > 0) begin
        if (bus.tx_ready) void'(exp_q.pop_front());
      end else if (bus.tx_ready) begin
        m_halt = 1;
      end
    end else begin
      popd    = (exp_q.size() > 0) && bus.tx_ready;
      io      = bus.rdy_in && bus.mem_wr && (bus.mem_a[17:16] == 2'b11);
      is_stop = io && bus.mem_a[2];
      if (popd) void'(exp_q.pop_front());
      if (is_stop) begin
        m_stop = 1;
      end else if (io && bus.mem_dout != 8'h00) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(bus.mem_dout);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic model_check(input string name);
    logic v;
    logic [7:0] d;
    v = !m_halt && (exp_q.size() > 0 || m_stop);
    d = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    check_out(name, v, d, m_stop || m_halt || (exp_q.size() >= DEPTH - MARGIN), m_halt, m_ovf);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{1, 1, 32'h0003_0000, 8'h41, 1,  1, 8'h41, 0, 0, 0};
    vecs[1] = '{1, 1, 32'h0003_0000, 8'h42, 1,  1, 8'h42, 0, 0, 0};
    vecs[2] = '{1, 0, 32'h0000_0000, 8'h00, 1,  0, 8'h00, 0, 0, 0};
    vecs[3] = '{1, 1, 32'h0003_0000, 8'h00, 1,  0, 8'h00, 0, 0, 0};
    vecs[4] = '{1, 1, 32'h0002_0000, 8'h55, 0,  0, 8'h00, 0, 0, 0};
    vecs[5] = '{1, 0, 32'h0003_0000, 8'h77, 0,  0, 8'h00, 0, 0, 0};
    vecs[6] = '{0, 1, 32'h0003_0000, 8'h66, 0,  0, 8'h00, 0, 0, 0};
    vecs[7] = '{1, 1, 32'hFFF3_0008, 8'h99, 0,  1, 8'h99, 0, 0, 0};
    vecs[8] = '{1, 0, 32'h0000_0000, 8'h00, 0,  1, 8'h99, 0, 0, 0};
    vecs[9] = '{1, 0, 32'h0000_0000, 8'h00, 1,  0, 8'h00, 0, 0, 0};

    rst = 1'b1;
    idle(1'b0);
    tick();
    tick();
    rst = 1'b0;
    check_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      set_bus(vecs[i].rdy, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].txr);
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].dat, vecs[i].full,
                vecs[i].stop, vecs[i].ovf);
    end

    // Fill to full threshold, to capacity, then overflow; drain in order.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      write_byte(8'(8'h11 + i), 1'b0);
      check_out($sformatf("fill%0d", i), 1'b1, 8'h11, (i >= DEPTH - MARGIN - 1),
                1'b0, (i >= DEPTH));
    end
    for (int j = 0; j < DEPTH; j++) begin
      idle(1'b1);
      check($sformatf("drain%0d.data", j), 32'(bus.tx_data), 32'(8'(8'h11 + j)));
      check($sformatf("drain%0d.valid", j), 32'(bus.tx_valid), 32'd1);
      tick();
    end
    check_out("drained", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Push into a full FIFO while the head pops in the same cycle.
    do_reset();
    for (int i = 0; i < DEPTH; i++) write_byte(8'(8'h21 + i), 1'b0);
    check_out("full8", 1'b1, 8'h21, 1'b1, 1'b0, 1'b0);
    write_byte(8'hAB, 1'b1);
    check_out("push_pop_full", 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < DEPTH; j++) begin
      idle(1'b1);
      check($sformatf("pp_drain%0d", j), 32'(bus.tx_data),
            (j == DEPTH - 1) ? 32'hAB : 32'(8'(8'h22 + j)));
      tick();
    end
    check_out("pp_empty", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Stop with buffered bytes: drain, NUL, halt, later writes ignored.
    do_reset();
    write_byte(8'h31, 1'b0);
    write_byte(8'h32, 1'b0);
    write_byte(8'h33, 1'b0);
    set_bus(1'b1, 1'b1, 32'h0003_0004, 8'h00, 1'b0);
    tick();
    check_out("stop.a", 1'b1, 8'h31, 1'b1, 1'b0, 1'b0);
    write_byte(8'h77, 1'b1);
    check_out("stop.b", 1'b1, 8'h32, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    tick();
    check_out("stop.c", 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("stop.nul", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    tick();
    check_out("stop.nul_hold", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    tick();
    check_out("stop.halt", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    write_byte(8'h55, 1'b1);
    check_out("stop.ignored", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // Stop on an empty buffer goes straight to NUL; reset aborts it.
    do_reset();
    set_bus(1'b1, 1'b1, 32'h0003_0004, 8'h5A, 1'b0);
    tick();
    check_out("nul_direct", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    idle(1'b0);
    tick();
    rst = 1'b0;
    check_out("nul_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    write_byte(8'h41, 1'b0);
    check_out("after_reset_run", 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int k;
      logic [31:0] a;
      logic txr;
      k = $urandom_range(0, 99);
      a = $urandom;
      if (k < 80) begin
        a[17:16] = 2'b11;
        a[2]     = 1'b0;
      end else if (k == 80) begin
        a[17:16] = 2'b11;
        a[2]     = 1'b1;
      end
      txr = (((cyc / 200) % 2) == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      set_bus(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), a,
              ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom), txr);
      rst = ($urandom_range(0, 299) == 0);
      model_step();
      tick();
      rst = 1'b0;
      model_check($sformatf("rand%0d", cyc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
